mux_sel_rr_scheduler: RTL and testbench

//  Upstream control stage for the 4:1 mux (inputs a,b,c,d; selects s1,s2; output y).

---
 rtl/mux_sel_rr_scheduler.sv | 138 +++++++++++++
 tb/tb_mux_sel_rr_scheduler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mux_sel_rr_scheduler.sv
// Round-robin select generator for a 4:1 mux: grants one request, settles, samples y, hands it downstream.
// Latency: request seen in IDLE at edge N gives out_valid after edge N+SETTLE_CYCLES+1.
// Backpressure: result held until out_ready; optional drop after TIMEOUT cycles when MUX_SCHED_TIMEOUT_EN is defined.
module mux_sel_rr_scheduler #(
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic       s1,
    output logic       s2,
    input  logic       y,
    output logic [3:0] grant,
    output logic       out_data,
    output logic [1:0] out_src,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] ack,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, OUTPUT} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr;
    logic [3:0] settle_cnt;
    logic [1:0] pick_idx;
    logic       pick_vld;
    logic       hs;
    logic       to_hit;

    assign busy = (state != IDLE);
    assign hs   = (state == OUTPUT) && out_ready;

    // First requesting input at or after ptr, wrapping modulo 4.
    always_comb begin
        pick_idx = 2'd0;
        pick_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] cand;
            cand = ptr + 2'(i);
            if (!pick_vld && req[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

`ifdef MUX_SCHED_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign to_hit = (state == OUTPUT) && !out_ready && (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (state == CAPTURE)
                wait_cnt <= 8'd0;
            else if (state == OUTPUT && !out_ready)
                wait_cnt <= wait_cnt + 8'd1;
            if (to_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == 4'd0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = OUTPUT;
            OUTPUT:  if (hs || to_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Select only moves on the IDLE->SETTLE edge so y is sampled from a quiet mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= 2'd0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            grant      <= 4'd0;
            settle_cnt <= 4'd0;
            out_data   <= 1'b0;
            out_src    <= 2'd0;
            out_valid  <= 1'b0;
            ack        <= 4'd0;
        end else begin
            ack <= 4'd0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        s1         <= pick_idx[1];
                        s2         <= pick_idx[0];
                        grant      <= 4'b0001 << pick_idx;
                        settle_cnt <= 4'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    if (settle_cnt != 4'd0)
                        settle_cnt <= settle_cnt - 4'd1;
                end
                CAPTURE: begin
                    out_data  <= y;
                    out_src   <= {s1, s2};
                    out_valid <= 1'b1;
                end
                OUTPUT: begin
                    if (hs || to_hit) begin
                        out_valid <= 1'b0;
                        grant     <= 4'd0;
                        ptr       <= {s1, s2} + 2'd1;
                        if (hs)
                            ack <= grant;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_rr_scheduler.sv
// Directed bench for mux_sel_rr_scheduler with a scoreboard of expected {src,data} per transfer.
module tb_mux_sel_rr_scheduler;
    localparam int SETTLE_CYCLES = 2;
    localparam int TIMEOUT       = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'd0;
    logic       y = 1'b0;
    logic       out_ready = 1'b0;
    logic       s1, s2, out_data, out_valid, busy, timeout_err;
    logic [1:0] out_src;
    logic [3:0] grant, ack;

    int total = 0;
    int bad   = 0;
    logic [2:0] sb_q[$];

    always #5 clk = ~clk;

    mux_sel_rr_scheduler #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .s1         (s1),
        .s2         (s2),
        .y          (y),
        .grant      (grant),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ack        (ack),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transfer starting from IDLE; caller has already driven req.
    task automatic do_xfer(input string tag, input logic [1:0] idx, input logic ybit,
                           input logic early, input int hold, input logic [3:0] req_after);
        int n;
        logic [2:0] exp;
        logic [2:0] snap;
        logic [3:0] onehot;
        n      = 0;
        onehot = 4'b0001 << idx;
        sb_q.push_back({idx, ybit});
        y         = ybit;
        out_ready = early;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, "_sel"}, {30'd0, s1, s2}, {30'd0, idx});
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
                req = req_after;
            end
        end while (!out_valid && n < 50);
        chk({tag, "_lat"}, n, SETTLE_CYCLES + 2);
        chk({tag, "_grant"}, {28'd0, grant}, {28'd0, onehot});
        snap = {out_src, out_data};
        for (int k = 0; k < hold; k++) begin
            y = ~y;
            @(negedge clk);
            chk({tag, "_hold"}, {26'd0, out_valid, s1, s2, out_src, out_data},
                {26'd0, 1'b1, idx, snap});
        end
        out_ready = 1'b1;
        exp = sb_q.pop_front();
        chk({tag, "_sb"}, {29'd0, out_src, out_data}, {29'd0, exp});
        @(negedge clk);
        chk({tag, "_ack"}, {28'd0, ack}, {28'd0, onehot});
        chk({tag, "_done"}, {26'd0, out_valid, grant, busy}, 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int m;

        // Reset values
        #1 rst = 1'b1;
        #3;
        chk("reset", {16'd0, s1, s2, grant, out_data, out_src, out_valid, ack, busy, timeout_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset while holding a result in OUTPUT
        req = 4'b1000; y = 1'b1; out_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        chk("rst_pre", {27'd0, out_valid, s1, s2, out_src}, {27'd0, 1'b1, 2'b11, 2'b11});
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {16'd0, s1, s2, grant, out_data, out_src, out_valid, ack, busy, timeout_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0100;
        do_xfer("rst_c", 2'd2, 1'b0, 1'b0, 0, 4'b0000);

        // ptr=3: a is chosen over c, and dropping req does not cancel the ack
        req = 4'b0101;
        do_xfer("wrap_a", 2'd0, 1'b1, 1'b1, 0, 4'b0000);
        req = 4'b0101;
        do_xfer("skip_c", 2'd2, 1'b1, 1'b1, 0, 4'b0000);

        // Single request on b with out_ready already high; ack lasts one cycle
        req = 4'b0010;
        do_xfer("single_b", 2'd1, 1'b1, 1'b1, 0, 4'b0000);
        @(negedge clk);
        chk("ack_pulse", {28'd0, ack}, 32'd0);

        // Backpressure with y toggling while the result is held
        req = 4'b1000;
        do_xfer("bp_d", 2'd3, 1'b0, 1'b0, 10, 4'b0000);

        // Fairness with every input requesting
        req = 4'b1111;
        for (int i = 0; i < 8; i++)
            do_xfer("fair", 2'(i % 4), (i % 3) == 0, 1'b1, 0, 4'b1111);
        req = 4'b0000;
        @(negedge clk);

`ifdef MUX_SCHED_TIMEOUT_EN
        req = 4'b0010; y = 1'b1; out_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        chk("to_vld", {31'd0, out_valid}, 32'd1);
        req = 4'b0000;
        m = 0;
        do begin
            @(negedge clk);
            m++;
            chk("to_noack", {28'd0, ack}, 32'd0);
        end while (out_valid && m < 50);
        chk("to_len", m, TIMEOUT);
        chk("to_err", {26'd0, timeout_err, grant, busy}, {26'd0, 1'b1, 4'b0000, 1'b0});
        req = 4'b0011;
        do_xfer("to_next", 2'd0, 1'b1, 1'b1, 0, 4'b0000);
        chk("to_sticky", {31'd0, timeout_err}, 32'd1);
`else
        req = 4'b0010;
        do_xfer("no_to", 2'd1, 1'b0, 1'b0, 40, 4'b0000);
        chk("no_to_err", {31'd0, timeout_err}, 32'd0);
`endif

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
